// File: rtl/melody_pkg.sv
// Shared types and helpers for the melody sequencer: FSM states, table entry layout,
// and the note-code sanitizer feeding the tone-divider block.
package melody_pkg;

  typedef enum logic [1:0] {StIdle, StFetch, StPlay, StGap} state_t;

  typedef struct packed {
    logic [5:0] note;
    logic [7:0] dur;
  } entry_t;

  localparam logic [5:0] REST = 6'b000000;

  // Note field 0 or octave 7 has no tone-block meaning; play it as a rest.
  function automatic logic [5:0] sanitize(input logic [5:0] note);
    if (note[2:0] == 3'd0 || note[5:3] == 3'd7) begin
      return REST;
    end
    return note;
  endfunction

endpackage

// File: rtl/melody_seq_tick_gen.sv
// Free-running divide-by-DIV tick source; tick is high in the last cycle of each period.
module tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rb,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/melody_seq.sv
// Melody sequencer: steps through a writable (note, duration) table and drives the
// tone-divider note code, with optional inter-note gap, stop and looping.
module melody_seq
  import melody_pkg::*;
#(
  parameter int unsigned  CLK_HZ    = 50_000_000,
  parameter int unsigned  TICK_HZ   = 100,
  parameter int unsigned  LEN       = 16,
  parameter int unsigned  GAP_TICKS = 2,
  localparam int unsigned AW        = $clog2(LEN)
) (
  input  logic          clk,
  input  logic          rb,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [5:0]    wr_note,
  input  logic [7:0]    wr_dur,
  output logic [5:0]    comb,
  output logic          busy,
  output logic [AW-1:0] idx,
  output logic          done
);

  localparam int unsigned   TICK_DIV = CLK_HZ / TICK_HZ;
  localparam logic [AW-1:0] LAST     = AW'(LEN - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [5:0]    comb_q, comb_d;
  logic [7:0]    rem_q, rem_d;
  logic          done_q, done_d;
  logic          tick, clr, adv, end_seq;

  entry_t mem [LEN];
  entry_t rdata_q;

  // Read address is the next idx so the entry is ready in the FETCH cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= '{note: wr_note, dur: wr_dur};
    end
    rdata_q <= mem[idx_d];
  end

  tick_gen #(
    .DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rb  (rb),
    .clr (clr),
    .tick(tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    comb_d  = comb_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    adv     = 1'b0;
    end_seq = 1'b0;

    unique case (state_q)
      StIdle: begin
        comb_d = REST;
        if (start && !stop) begin
          idx_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (rdata_q.dur != 8'd0) begin
          state_d = StPlay;
          comb_d  = sanitize(rdata_q.note);
          rem_d   = rdata_q.dur;
          clr     = 1'b1;
        end else begin
          end_seq = 1'b1;
        end
      end
      StPlay: begin
        if (tick) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            if (GAP_TICKS != 0) begin
              state_d = StGap;
              comb_d  = REST;
              rem_d   = 8'(GAP_TICKS);
              clr     = 1'b1;
            end else begin
              adv = 1'b1;
            end
          end
        end
      end
      StGap: begin
        if (tick) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            adv = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (adv) begin
      if (idx_q != LAST) begin
        idx_d   = idx_q + 1'b1;
        state_d = StFetch;
      end else begin
        end_seq = 1'b1;
      end
    end

    // Entry 0 never loops back onto itself, so an empty melody cannot spin forever.
    if (end_seq) begin
      if (loop && idx_q != '0) begin
        idx_d   = '0;
        state_d = StFetch;
      end else begin
        state_d = StIdle;
        comb_d  = REST;
        done_d  = 1'b1;
      end
    end

    if (stop && state_q != StIdle) begin
      state_d = StIdle;
      idx_d   = idx_q;
      comb_d  = REST;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rb) begin
      state_q <= StIdle;
      idx_q   <= '0;
      comb_q  <= REST;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      comb_q  <= comb_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  assign comb = comb_q;
  assign idx  = idx_q;
  assign done = done_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_melody_seq.sv
// Bench for melody_seq: two instances (gap of one tick, legato) checked cycle by cycle
// against an expected output timeline built from the table with note/gap arithmetic.
module tb_melody_seq;

  localparam int TDIV = 10;

  logic       clk = 1'b0, rb = 1'b0, start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [5:0] wr_note = '0;
  logic [7:0] wr_dur = '0;
  logic [5:0] comb, comb0;
  logic       busy, busy0, done, done0;
  logic [1:0] idx, idx0;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [5:0] comb;
    logic       busy;
    logic [1:0] idx;
    logic       done;
  } obs_t;

  obs_t       exp_q[$];
  logic [5:0] tn[4];
  logic [7:0] td[4];
  int         loop_drop = 0, stop_at = -1, rst_at = -1, pw_at = -1;
  logic [1:0] pw_addr;
  logic [5:0] pw_note;
  logic [7:0] pw_dur;

  melody_seq #(.CLK_HZ(1000), .TICK_HZ(100), .LEN(4), .GAP_TICKS(1)) dut (
    .clk(clk), .rb(rb), .start(start), .stop(stop), .loop(loop), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_note(wr_note), .wr_dur(wr_dur),
    .comb(comb), .busy(busy), .idx(idx), .done(done)
  );

  melody_seq #(.CLK_HZ(1000), .TICK_HZ(100), .LEN(4), .GAP_TICKS(0)) dut0 (
    .clk(clk), .rb(rb), .start(start), .stop(stop), .loop(loop), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_note(wr_note), .wr_dur(wr_dur),
    .comb(comb0), .busy(busy0), .idx(idx0), .done(done0)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] san(input logic [5:0] n);
    return (n[2:0] == 3'd0 || n[5:3] == 3'd7) ? 6'd0 : n;
  endfunction

  task automatic chk(input string tag, input obs_t o, input obs_t e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, o, e);
    end
  endtask

  // Timeline: FETCH (1 cycle, prior comb), note for dur*TDIV, rest for gap*TDIV.
  task automatic build(input bit g0, input int ncyc);
    logic [5:0] n_tab[4];
    logic [7:0] d_tab[4];
    logic [5:0] prev, n;
    int         i, gap, f;
    bit         fin, endhit;
    n_tab = tn;
    d_tab = td;
    i = 0;
    gap = g0 ? 0 : 1;
    prev = 6'd0;
    fin = 1'b0;
    exp_q.delete();
    while (!fin && exp_q.size() < ncyc) begin
      f = exp_q.size();
      if (pw_at >= 0 && f >= pw_at + 2) begin
        n_tab[pw_addr] = pw_note;
        d_tab[pw_addr] = pw_dur;
      end
      exp_q.push_back('{prev, 1'b1, 2'(i), 1'b0});
      endhit = 1'b0;
      if (d_tab[i] == 8'd0) begin
        endhit = 1'b1;
      end else begin
        n = san(n_tab[i]);
        repeat (int'(d_tab[i]) * TDIV) exp_q.push_back('{n, 1'b1, 2'(i), 1'b0});
        prev = n;
        repeat (gap * TDIV) exp_q.push_back('{6'd0, 1'b1, 2'(i), 1'b0});
        if (gap > 0) prev = 6'd0;
        endhit = (i == 3);
        if (!endhit) i++;
      end
      if (endhit) begin
        if (exp_q.size() - 1 < loop_drop && i != 0) i = 0;
        else fin = 1'b1;
      end
    end
    if (fin) exp_q.push_back('{6'd0, 1'b0, 2'(i), 1'b1});
    while (exp_q.size() < ncyc) exp_q.push_back('{6'd0, 1'b0, 2'(i), 1'b0});
    if (stop_at >= 0)
      for (int c = stop_at + 1; c < exp_q.size(); c++)
        exp_q[c] = '{6'd0, 1'b0, exp_q[stop_at].idx, 1'b0};
    if (rst_at >= 0)
      for (int c = rst_at + 1; c < exp_q.size(); c++) exp_q[c] = '0;
  endtask

  task automatic idle();
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [5:0] n, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_note = n; wr_dur = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    tn[a] = n;
    td[a] = d;
  endtask

  task automatic go(input bit g0, input int ncyc, input string tag);
    obs_t o;
    build(g0, ncyc);
    loop = (loop_drop > 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (c == loop_drop) loop = 1'b0;
      if (c == stop_at) stop = 1'b1; else if (c == stop_at + 1) stop = 1'b0;
      if (c == rst_at) rb = 1'b0; else if (c == rst_at + 1) rb = 1'b1;
      if (c == pw_at) begin
        wr_en = 1'b1; wr_addr = pw_addr; wr_note = pw_note; wr_dur = pw_dur;
      end else begin
        wr_en = 1'b0;
      end
      o = g0 ? {comb0, busy0, idx0, done0} : {comb, busy, idx, done};
      chk($sformatf("%s c%0d", tag, c), o, exp_q[c]);
      @(posedge clk); #1;
    end
    wr_en = 1'b0; stop = 1'b0; rb = 1'b1; loop = 1'b0;
    if (pw_at >= 0) begin
      tn[pw_addr] = pw_note;
      td[pw_addr] = pw_dur;
    end
    loop_drop = 0; stop_at = -1; rst_at = -1; pw_at = -1;
    idle();
  endtask

  initial begin
    rb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset dut", {comb, busy, idx, done}, '0);
    chk("reset dut0", {comb0, busy0, idx0, done0}, '0);
    rb = 1'b1;

    // Basic play with one-tick gap
    wr(2'd0, 6'o21, 8'd3);
    wr(2'd1, 6'o23, 8'd2);
    wr(2'd2, 6'o55, 8'd0);
    wr(2'd3, 6'o11, 8'd1);
    go(1'b0, 80, "basic");

    // Reset mid-PLAY, then the retained table plays again
    rst_at = 10;
    go(1'b0, 15, "rst");
    go(1'b0, 80, "after_rst");

    // Stop priority in IDLE, then stop in the 5th PLAY cycle
    start = 1'b1; stop = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("start+stop idle", {busy, busy0}, 2'b00);
    end
    start = 1'b0; stop = 1'b0;
    stop_at = 5;
    go(1'b0, 20, "stop");

    // Full table, legato, loop then drop loop during the second pass
    wr(2'd0, 6'o41, 8'd1);
    wr(2'd1, 6'o42, 8'd1);
    wr(2'd2, 6'o43, 8'd1);
    wr(2'd3, 6'o44, 8'd1);
    loop_drop = 60;
    go(1'b1, 95, "loop");

    // Write entry 1 while it plays; the change appears on the next pass
    pw_at = 25; pw_addr = 2'd1; pw_note = 6'o67; pw_dur = 8'd2;
    loop_drop = 1000;
    go(1'b0, 130, "wr_play");

    // Invalid octave plays as rest; marker at entry 0 ends even with loop set
    wr(2'd0, 6'o70, 8'd2);
    wr(2'd1, 6'o12, 8'd0);
    go(1'b0, 40, "sanitize");
    wr(2'd0, 6'o33, 8'd0);
    loop_drop = 1000;
    go(1'b0, 5, "marker0");

    for (int r = 0; r < 5; r++) begin
      bit g;
      for (int e = 0; e < 4; e++)
        wr(2'(e), 6'($urandom), 8'($urandom_range(0, 3)));
      g = 1'($urandom_range(0, 1));
      loop_drop = $urandom_range(0, 150);
      go(g, 160, $sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
